ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain clock/data pair the existing keyboard receiver listens on. It takes a byte through a valid/ready handshake, runs the inhibit / request-to-send / device-clocked shift sequence, and checks the device ACK. Output enables drive the pads low; the top level ties the pads as open-drain.

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum cycles between consecutive device falling edges, including the first (15 ms at 50 MHz)
FILTER_LEN, 4, consecutive equal samples needed to accept a new ps2_clk level (used only with the optional feature)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  command byte valid
i_data  input  8  command byte
o_ready  output  1  high only in IDLE; transfer accepted on i_valid && o_ready
i_ps2_clk  input  1  raw ps2 clock pad level
i_ps2_data  input  1  raw ps2 data pad level
o_ps2_clk_oe  output  1  1 = pull ps2 clock low, 0 = release
o_ps2_data_oe  output  1  1 = pull ps2 data low, 0 = release
o_busy  output  1  transfer in progress
o_done  output  1  one-cycle pulse: byte sent and ACK received
o_err  output  1  one-cycle pulse: transfer failed
o_err_code  output  2  valid with o_err: 01 timeout, 10 no ACK; holds its value until the next error

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; both oe=0 (lines released); o_ready=1; o_busy=0; o_done=0; o_err=0; o_err_code=00; counters cleared. A reset mid-frame releases both lines at the same edge.
- Pad inputs pass through a 2-FF synchronizer. A falling edge (fe) is sync_clk 1->0, detected one cycle after the synchronized level changes.
- Accept: on i_valid && o_ready, latch i_data, compute parity = ~^i_data (odd parity), set bit index to 0, enter INHIBIT. o_busy=1 from the next cycle.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. data_oe is asserted on the final INHIBIT cycle (start bit = 0).
- RTS: clk_oe=0, data_oe=1. Wait for fe with the timeout counter running.
- SHIFT: on fe n (n=1..8), drive data bit n-1, LSB first; data_oe = ~bit. After the 8th bit, go to PARITY.
- PARITY: on fe 9, data_oe = ~parity.
- STOP: on fe 10, data_oe=0 (release = stop bit 1).
- ACK: on fe 11, sample sync_data. A 0 goes to WAIT_IDLE; a 1 sets o_err with code 10 and returns to IDLE.
- WAIT_IDLE: wait until sync_clk=1 and sync_data=1, then pulse o_done for one cycle and go to IDLE.
- Timeout: the counter resets on entry to RTS and on every fe. Reaching TIMEOUT_CYCLES in RTS, SHIFT, PARITY, STOP, ACK or WAIT_IDLE releases both lines and pulses o_err with code 01, then returns to IDLE.
- o_done and o_err are never asserted in the same cycle.
- o_ready returns to 1 in the cycle after a done or error pulse. i_valid is ignored while busy; i_data is not sampled after accept.
- An fe occurring during INHIBIT (the host is holding the line, so it is spurious) is ignored.

Optional Feature:
PS2_TX_CLK_FILTER_EN
- Defined: sync_clk is replaced by a debounced level that changes only after FILTER_LEN consecutive equal samples, adding FILTER_LEN cycles of edge latency. Glitches shorter than FILTER_LEN cycles produce no fe.
- Undefined: plain 2-FF synchronizer; the FILTER_LEN parameter is unused.

Decomposition:
- ps2_pkg: tx state enum (IDLE, INHIBIT, RTS, SHIFT, PARITY, STOP, ACK, WAIT_IDLE), error code constants ERR_NONE/ERR_TIMEOUT/ERR_NOACK, odd-parity function. It is shared with the keyboard receiver for parity checking.
- Sub-module ps2_line_sync: synchronizer, optional filter and fe detect, instantiated once for clock and once for data (data without fe use).

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing -> data bits 1,0,1,1,0,1,1,1 on fe 1-8; parity 1 on fe 9; line released on fe 10; o_done pulse; o_err never asserted.
- Send 0x07 -> parity bit 0 on fe 9; INHIBIT measured as exactly 5000 cycles with clk_oe=1 and data_oe asserted only in the last cycle.
- Device never clocks after RTS -> o_err pulse with code 01 exactly TIMEOUT_CYCLES after clock release; both oe=0; o_ready=1 next cycle.
- Device holds data high on fe 11 for 0xFF -> o_err with code 10, no o_done; the next transfer of 0x00 then succeeds with parity 1.
- Assert i_rst during fe 5 of 0xF4 -> both oe=0 and o_busy=0 after that edge; a new 0xF4 completes normally; i_valid pulsed while busy has no effect.
- With PS2_TX_CLK_FILTER_EN, inject 2-cycle low glitches on ps2_clk between edges -> bit sequence unchanged, o_done still asserted.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 tx state enum, error codes and odd-parity helper
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } tx_state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK = 2'b10;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF pad synchronizer with optional debounce filter and falling-edge detect
module ps2_line_sync #(
  parameter int FILTER_LEN = 4,
  parameter bit FILTER_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fe
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic s1, s2, flt, prev;
  logic [FW-1:0] fcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      flt <= 1'b1;
      prev <= 1'b1;
      fcnt <= '0;
    end else begin
      s1 <= pad;
      s2 <= s1;
      prev <= level;
      fcnt <= (s2 == flt || fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
      flt <= (s2 != flt && fcnt == FW'(FILTER_LEN - 1)) ? s2 : flt;
    end
  end
  assign level = FILTER_EN ? flt : s2;
  assign fe = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter; PS2_TX_CLK_FILTER_EN debounces ps2_clk
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);
`ifdef PS2_TX_CLK_FILTER_EN
  localparam bit CLK_FILTER = 1'b1;
`else
  localparam bit CLK_FILTER = 1'b0;
`endif
  localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [2:0] idx, idx_n;
  logic par, par_n, drv, drv_n;
  logic [1:0] code, err_now;
  logic sync_clk, sync_data, clk_fe, unused_data_fe;
  logic active, timeout;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(CLK_FILTER)) u_clk_sync (
    .clk(i_clk), .rst(i_rst), .pad(i_ps2_clk), .level(sync_clk), .fe(clk_fe)
  );
  ps2_line_sync #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b0)) u_data_sync (
    .clk(i_clk), .rst(i_rst), .pad(i_ps2_data), .level(sync_data), .fe(unused_data_fe)
  );

  assign active = state inside {RTS, SHIFT, PARITY, STOP, ACK, WAIT_IDLE};
  assign timeout = active && cnt == CW'(TIMEOUT_CYCLES);

  always_comb begin
    state_n = state;
    cnt_n = active ? (clk_fe ? '0 : cnt + 1'b1) : cnt;
    sh_n = sh;
    idx_n = idx;
    par_n = par;
    drv_n = drv;
    o_done = 1'b0;
    o_err = 1'b0;
    err_now = ERR_NONE;
    case (state)
      IDLE: if (i_valid) begin
        state_n = INHIBIT;
        sh_n = i_data;
        par_n = odd_parity(i_data);
        idx_n = '0;
        cnt_n = '0;
      end
      INHIBIT: begin
        cnt_n = cnt == CW'(INHIBIT_CYCLES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
      end
      RTS: if (clk_fe) begin
        drv_n = ~sh[0];
        idx_n = 3'd1;
        state_n = SHIFT;
      end
      SHIFT: if (clk_fe) begin
        drv_n = ~sh[idx];
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? PARITY : SHIFT;
      end
      PARITY: if (clk_fe) begin
        drv_n = ~par;
        state_n = STOP;
      end
      STOP: if (clk_fe) begin
        drv_n = 1'b0;
        state_n = ACK;
      end
      ACK: if (clk_fe) begin
        o_err = sync_data;
        err_now = sync_data ? ERR_NOACK : ERR_NONE;
        state_n = sync_data ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (sync_clk && sync_data) begin
        o_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      o_done = 1'b0;
      o_err = 1'b1;
      err_now = ERR_TIMEOUT;
      drv_n = 1'b0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      idx <= '0;
      par <= 1'b0;
      drv <= 1'b0;
      code <= ERR_NONE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      idx <= idx_n;
      par <= par_n;
      drv <= drv_n;
      code <= o_err ? err_now : code;
    end
  end

  assign o_ready = state == IDLE;
  assign o_busy = state != IDLE;
  assign o_ps2_clk_oe = state == INHIBIT;
  assign o_ps2_data_oe = (state == INHIBIT && cnt == CW'(INHIBIT_CYCLES - 1)) || state == RTS || drv;
  assign o_err_code = o_err ? err_now : code;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 60;
  localparam int TMO = 500;
  localparam int H = 40;

  typedef struct {
    logic is_err;
    logic [1:0] code;
    logic [7:0] data;
    logic frame;
    logic timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [7:0] data = '0;
  logic ready, clk_oe, data_oe, busy, done, err;
  logic [1:0] err_code;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk, ps2_data;
  logic [10:0] cap = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int inh_len = 0;
  int inh_doe = 0;
  logic inh_last = 1'b0;
  logic prev_clk_oe = 1'b0;
  logic post = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  assign ps2_clk = ~clk_oe & dev_clk;
  assign ps2_data = ~data_oe & dev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(ready),
    .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data), .o_ps2_clk_oe(clk_oe),
    .o_ps2_data_oe(data_oe), .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (clk_oe) begin
        inh_len++;
        inh_doe += int'(data_oe);
        inh_last = data_oe;
      end else if (ready) begin
        inh_len = 0;
        inh_doe = 0;
        inh_last = 1'b0;
      end
      if (prev_clk_oe && !clk_oe) rel_cyc = cyc;
      prev_clk_oe = clk_oe;
      if (post) begin
        chk("post_ready", 32'(ready), 1);
        chk("post_clk_oe", 32'(clk_oe), 0);
        chk("post_data_oe", 32'(data_oe), 0);
        post = 1'b0;
      end
      if (done || err) begin
        chk("done_err_exclusive", 32'(done & err), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got done=%0b err=%0b expected none", done, err);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_is_err", 32'(err), 32'(mon_e.is_err));
          if (mon_e.is_err) chk("err_code", 32'(err_code), 32'(mon_e.code));
          chk("inhibit_len", inh_len, INH);
          chk("inhibit_data_oe_cycles", inh_doe, 1);
          chk("inhibit_last_data_oe", 32'(inh_last), 1);
          if (mon_e.frame) begin
            chk("start_bit", 32'(cap[0]), 0);
            chk("data_bits", 32'(cap[8:1]), 32'(mon_e.data));
            chk("parity_bit", 32'(cap[9]), 32'(($countones(mon_e.data) % 2) == 0));
            chk("stop_bit", 32'(cap[10]), 1);
          end
          if (mon_e.timeout) chk("timeout_latency", cyc - rel_cyc, TMO);
        end
        post = 1'b1;
      end
    end
  end

  task automatic dev_run(input int mode, input logic [7:0] b);
    int n = 0;
    cap = '0;
    while (!(ps2_clk && !ps2_data) && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    if (!(ps2_clk && !ps2_data)) begin
      checks++;
      errors++;
      $display("FAIL rts_wait: got no request-to-send expected one within %0d cycles", 4 * INH);
      return;
    end
    if (mode == 2) return;
    repeat (10) @(negedge clk);
    cap[0] = ps2_data;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      if (mode == 3 && k == 5) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clk_oe", 32'(clk_oe), 0);
        chk("rst_data_oe", 32'(data_oe), 0);
        chk("rst_ready", 32'(ready), 1);
        rst = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      if (k == 2 && mode < 2) begin
        valid = 1'b1;
        data = ~b;
        @(negedge clk);
        valid = 1'b0;
      end
      repeat (H - 4) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
      cap[k] = ps2_data;
`ifdef PS2_TX_CLK_FILTER_EN
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (2) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H / 2 - 7) @(negedge clk);
`else
      repeat (H / 2) @(negedge clk);
`endif
    end
    if (mode == 0) dev_data = 1'b0;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int mode);
    exp_t e;
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got ready=0 expected 1 within 3000 cycles");
      return;
    end
    e.is_err = mode == 1 || mode == 2;
    e.code = mode == 1 ? 2'b10 : 2'b01;
    e.data = b;
    e.frame = mode < 2;
    e.timeout = mode == 2;
    if (mode != 3) sb.push_back(e);
    valid = 1'b1;
    data = b;
    @(negedge clk);
    valid = 1'b0;
    data = 8'($urandom);
    dev_run(mode, b);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected one within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_clk_oe", 32'(clk_oe), 0);
    chk("reset_data_oe", 32'(data_oe), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_err_code", 32'(err_code), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'hED, 0);
    send(8'h07, 0);
    send(8'h5A, 2);
    send(8'hFF, 1);
    send(8'h00, 0);
    send(8'hF4, 3);
    send(8'hF4, 0);
    for (int i = 0; i < 20; i++) send(8'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
